// File: rtl/mem_arb_pkg.sv
// Shared definitions for the cache-refill memory read arbiter: FSM encodings,
// client indices and the default burst length.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE = 3'b001,
    ARB_REQ  = 3'b010,
    ARB_RESP = 3'b100
  } arb_state_e;

  localparam logic CLI_IC = 1'b0;
  localparam logic CLI_DC = 1'b1;

  localparam int ARB_BEATS = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the client
// that was not granted last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt,
  output logic       gnt_idx,
  output logic       any
);

  always_comb begin
    any     = |req;
    gnt_idx = (req == 2'b11) ? ~last_grant : req[CLI_DC];
    gnt     = 2'b00;
    if (any) gnt = (gnt_idx == CLI_DC) ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/mem_rd_arbiter.sv
// Shares one memory read channel between I-cache and D-cache refills: one
// burst in flight, round-robin grant, responses routed to the granted client.
module mem_rd_arbiter
  import mem_arb_pkg::*;
#(
  parameter int BEATS = ARB_BEATS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  from_cli_rd_req_valid,
  input  logic [63:0] from_cli_rd_req_addr,
  output logic [1:0]  to_cli_rd_req_ready,
  output logic [1:0]  to_cli_rd_rsp_valid,
  output logic [31:0] to_cli_rd_rsp_data,
  output logic        to_cli_rd_rsp_last,
  input  logic [1:0]  from_cli_rd_rsp_ready,
  output logic        to_mem_rd_req_valid,
  output logic [31:0] to_mem_rd_req_addr,
  input  logic        from_mem_rd_req_ready,
  input  logic        from_mem_rd_rsp_valid,
  input  logic [31:0] from_mem_rd_rsp_data,
  input  logic        from_mem_rd_rsp_last,
  output logic        to_mem_rd_rsp_ready,
  output logic        protocol_err
);

  localparam int CNT_W = $clog2(BEATS);

  arb_state_e       state;
  logic             grant_q;
  logic             last_grant;
  logic [31:0]      addr_q;
  logic [CNT_W-1:0] cnt;

  logic [1:0]  pick;
  logic        pick_idx;
  logic        pick_any;
  logic [31:0] pick_addr;
  logic [1:0]  gsel;
  logic        in_idle;
  logic        in_resp;
  logic        beat_hs;

  rr_arb2 u_rr (
    .req        (from_cli_rd_req_valid),
    .last_grant (last_grant),
    .gnt        (pick),
    .gnt_idx    (pick_idx),
    .any        (pick_any)
  );

  assign in_idle   = (state == ARB_IDLE);
  assign in_resp   = (state == ARB_RESP);
  assign pick_addr = (pick_idx == CLI_DC) ? from_cli_rd_req_addr[63:32]
                                          : from_cli_rd_req_addr[31:0];
  assign gsel      = (grant_q == CLI_DC) ? 2'b10 : 2'b01;

  // Client ready depends only on client valids and registered state, never on
  // the memory side.
  assign to_cli_rd_req_ready = in_idle ? pick : 2'b00;

  assign to_mem_rd_req_valid = (state == ARB_REQ);
  assign to_mem_rd_req_addr  = addr_q;

  // Response channel is pure routing; no storage on the beat path.
  assign to_cli_rd_rsp_valid = (in_resp && from_mem_rd_rsp_valid) ? gsel : 2'b00;
  assign to_cli_rd_rsp_data  = from_mem_rd_rsp_data;
  assign to_cli_rd_rsp_last  = from_mem_rd_rsp_last;
  assign to_mem_rd_rsp_ready = in_resp && from_cli_rd_rsp_ready[grant_q];

  assign beat_hs = in_resp && from_mem_rd_rsp_valid && from_cli_rd_rsp_ready[grant_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ARB_IDLE;
      grant_q      <= CLI_IC;
      last_grant   <= CLI_DC;
      addr_q       <= 32'h0;
      cnt          <= '0;
      protocol_err <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: if (pick_any) begin
          addr_q     <= pick_addr;
          grant_q    <= pick_idx;
          last_grant <= pick_idx;
          state      <= ARB_REQ;
        end
        ARB_REQ: if (from_mem_rd_req_ready) begin
          cnt   <= '0;
          state <= ARB_RESP;
        end
        ARB_RESP: if (beat_hs) begin
          cnt <= cnt + 1'b1;
          // last must coincide exactly with the final beat; either way the
          // burst only ends on last so the memory side stays in sync.
          if (from_mem_rd_rsp_last != (cnt == CNT_W'(BEATS - 1)))
            protocol_err <= 1'b1;
          if (from_mem_rd_rsp_last) state <= ARB_IDLE;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_rd_arbiter.sv
// Directed bench for mem_rd_arbiter: per-cycle vector table plus hand-written
// protocol-error and reset-abort sequences.
module tb_mem_rd_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  cv;
  logic [63:0] ca;
  logic [1:0]  crq;
  logic [1:0]  rv;
  logic [31:0] rd;
  logic        rl;
  logic [1:0]  crr;
  logic        mqv;
  logic [31:0] mqa;
  logic        mqr;
  logic        mv;
  logic [31:0] md;
  logic        ml;
  logic        mrr;
  logic        err;

  int nvec  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  mem_rd_arbiter #(.BEATS(8)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .from_cli_rd_req_valid (cv),
    .from_cli_rd_req_addr  (ca),
    .to_cli_rd_req_ready   (crq),
    .to_cli_rd_rsp_valid   (rv),
    .to_cli_rd_rsp_data    (rd),
    .to_cli_rd_rsp_last    (rl),
    .from_cli_rd_rsp_ready (crr),
    .to_mem_rd_req_valid   (mqv),
    .to_mem_rd_req_addr    (mqa),
    .from_mem_rd_req_ready (mqr),
    .from_mem_rd_rsp_valid (mv),
    .from_mem_rd_rsp_data  (md),
    .from_mem_rd_rsp_last  (ml),
    .to_mem_rd_rsp_ready   (mrr),
    .protocol_err          (err)
  );

  typedef struct {
    string       tag;
    logic        r;
    logic [1:0]  cv;
    logic [63:0] ca;
    logic [1:0]  crr;
    logic        mqr;
    logic        mv;
    logic [31:0] md;
    logic        ml;
    logic [1:0]  e_crq;
    logic        e_mqv;
    logic [31:0] e_mqa;
    logic [1:0]  e_rv;
    logic        e_mrr;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(string tag, logic r, logic [1:0] icv, logic [63:0] ica,
                              logic [1:0] icrr, logic imqr, logic imv, logic [31:0] imd,
                              logic iml, logic [1:0] e_crq, logic e_mqv, logic [31:0] e_mqa,
                              logic [1:0] e_rv, logic e_mrr, logic e_err);
    vec_t v;
    v.tag = tag; v.r = r; v.cv = icv; v.ca = ica; v.crr = icrr; v.mqr = imqr;
    v.mv = imv; v.md = imd; v.ml = iml; v.e_crq = e_crq; v.e_mqv = e_mqv;
    v.e_mqa = e_mqa; v.e_rv = e_rv; v.e_mrr = e_mrr; v.e_err = e_err;
    return v;
  endfunction

  // Inputs driven at posedge+1, outputs checked 1 time unit later.
  task automatic apply(input vec_t v);
    rst = v.r; cv = v.cv; ca = v.ca; crr = v.crr; mqr = v.mqr;
    mv = v.mv; md = v.md; ml = v.ml;
    #1;
    nvec++;
    if ({crq, mqv, mqa, rv, mrr, err, rd, rl} !==
        {v.e_crq, v.e_mqv, v.e_mqa, v.e_rv, v.e_mrr, v.e_err, v.md, v.ml}) begin
      nfail++;
      $display("FAIL %s (vec %0d): got crq=%b mqv=%b mqa=%h rv=%b mrr=%b err=%b d=%h l=%b; want crq=%b mqv=%b mqa=%h rv=%b mrr=%b err=%b d=%h l=%b",
               v.tag, nvec, crq, mqv, mqa, rv, mrr, err, rd, rl,
               v.e_crq, v.e_mqv, v.e_mqa, v.e_rv, v.e_mrr, v.e_err, v.md, v.ml);
    end
    @(posedge clk);
    #1;
  endtask

  // Grant cycle, nwait REQ cycles with memory not ready, then the accept cycle.
  task automatic add_req(string tag, logic [1:0] icv, logic [63:0] ica, logic [1:0] e_crq,
                         logic [31:0] prev, logic [31:0] nxt, int nwait, logic [1:0] cv_hold);
    tbl.push_back(mk({tag, "-grant"}, 1'b1, icv, ica, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0,
                     e_crq, 1'b0, prev, 2'b00, 1'b0, 1'b0));
    for (int i = 0; i < nwait; i++)
      tbl.push_back(mk({tag, "-reqwait"}, 1'b1, cv_hold, ica, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0,
                       2'b00, 1'b1, nxt, 2'b00, 1'b0, 1'b0));
    tbl.push_back(mk({tag, "-req"}, 1'b1, cv_hold, ica, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0,
                     2'b00, 1'b1, nxt, 2'b00, 1'b0, 1'b0));
  endtask

  // Eight beats base..base+7; client ready drops for 3 cycles before beat stall_at.
  task automatic add_burst(string tag, logic cli, logic [1:0] icv, logic [63:0] ica,
                           logic [31:0] a, logic [31:0] base, int stall_at);
    logic [1:0] oh;
    oh = cli ? 2'b10 : 2'b01;
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at)
        for (int s = 0; s < 3; s++)
          tbl.push_back(mk({tag, "-stall"}, 1'b1, icv, ica, 2'b00, 1'b0, 1'b1, base + 32'(i),
                           1'b0, 2'b00, 1'b0, a, oh, 1'b0, 1'b0));
      tbl.push_back(mk({tag, "-beat"}, 1'b1, icv, ica, oh, 1'b0, 1'b1, base + 32'(i), i == 7,
                       2'b00, 1'b0, a, oh, 1'b1, 1'b0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; cv = 2'b00; ca = 64'h0; crr = 2'b00; mqr = 1'b0;
    mv = 1'b0; md = 32'h0; ml = 1'b0;

    // ---- vector table ----
    tbl.push_back(mk("reset", 1'b0, 2'b00, 64'h0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0,
                     2'b00, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0));
    add_req("ic1", 2'b01, {32'h0, 32'h0000_1020}, 2'b01, 32'h0, 32'h0000_1020, 1, 2'b00);
    add_burst("ic1", 1'b0, 2'b00, 64'h0, 32'h0000_1020, 32'h10, 99);
    tbl.push_back(mk("ic1-idle", 1'b1, 2'b00, 64'h0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0,
                     2'b00, 1'b0, 32'h0000_1020, 2'b00, 1'b0, 1'b0));
    tbl.push_back(mk("reset2", 1'b0, 2'b00, 64'h0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0,
                     2'b00, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0));
    // Tie from reset: I-cache first, D-cache waits through the whole burst.
    add_req("tie1", 2'b11, {32'h200, 32'h100}, 2'b01, 32'h0, 32'h100, 0, 2'b10);
    add_burst("tie1", 1'b0, 2'b10, {32'h200, 32'h100}, 32'h100, 32'h20, 99);
    add_req("dc1", 2'b10, {32'h200, 32'h100}, 2'b10, 32'h100, 32'h200, 0, 2'b00);
    // D-cache stalls mid-burst while the I-cache is already requesting.
    add_burst("dc1", 1'b1, 2'b01, {32'h200, 32'h300}, 32'h200, 32'h30, 3);
    add_req("tie2", 2'b11, {32'h200, 32'h300}, 2'b01, 32'h200, 32'h300, 0, 2'b10);
    add_burst("tie2", 1'b0, 2'b10, {32'h200, 32'h300}, 32'h300, 32'h40, 99);
    add_req("tie3", 2'b11, {32'h280, 32'h380}, 2'b10, 32'h300, 32'h280, 0, 2'b00);
    add_burst("tie3", 1'b1, 2'b00, {32'h280, 32'h380}, 32'h280, 32'h50, 99);
    tbl.push_back(mk("tie3-idle", 1'b1, 2'b00, 64'h0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0,
                     2'b00, 1'b0, 32'h280, 2'b00, 1'b0, 1'b0));

    @(posedge clk);
    #1;
    foreach (tbl[i]) apply(tbl[i]);

    // ---- early last on beat 5: sticky error, next burst unaffected ----
    apply(mk("perr-grant", 1'b1, 2'b01, {32'h0, 32'h3000}, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0,
             2'b01, 1'b0, 32'h280, 2'b00, 1'b0, 1'b0));
    apply(mk("perr-req", 1'b1, 2'b00, 64'h0, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0,
             2'b00, 1'b1, 32'h3000, 2'b00, 1'b0, 1'b0));
    for (int i = 0; i < 5; i++)
      apply(mk("perr-beat", 1'b1, 2'b00, 64'h0, 2'b01, 1'b0, 1'b1, 32'h60 + 32'(i), i == 4,
               2'b00, 1'b0, 32'h3000, 2'b01, 1'b1, 1'b0));
    apply(mk("perr-flag", 1'b1, 2'b01, {32'h0, 32'h3020}, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0,
             2'b01, 1'b0, 32'h3000, 2'b00, 1'b0, 1'b1));
    apply(mk("perr-req2", 1'b1, 2'b00, 64'h0, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0,
             2'b00, 1'b1, 32'h3020, 2'b00, 1'b0, 1'b1));
    for (int i = 0; i < 8; i++)
      apply(mk("perr-beat2", 1'b1, 2'b00, 64'h0, 2'b01, 1'b0, 1'b1, 32'h70 + 32'(i), i == 7,
               2'b00, 1'b0, 32'h3020, 2'b01, 1'b1, 1'b1));
    apply(mk("perr-idle", 1'b1, 2'b00, 64'h0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0,
             2'b00, 1'b0, 32'h3020, 2'b00, 1'b0, 1'b1));

    // ---- reset after 4 beats aborts the burst; a fresh burst then completes ----
    apply(mk("rab-grant", 1'b1, 2'b01, {32'h0, 32'h4000}, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0,
             2'b01, 1'b0, 32'h3020, 2'b00, 1'b0, 1'b1));
    apply(mk("rab-req", 1'b1, 2'b00, 64'h0, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0,
             2'b00, 1'b1, 32'h4000, 2'b00, 1'b0, 1'b1));
    for (int i = 0; i < 4; i++)
      apply(mk("rab-beat", 1'b1, 2'b00, 64'h0, 2'b01, 1'b0, 1'b1, 32'h80 + 32'(i), 1'b0,
               2'b00, 1'b0, 32'h4000, 2'b01, 1'b1, 1'b1));
    apply(mk("rab-rst", 1'b0, 2'b00, 64'h0, 2'b01, 1'b0, 1'b1, 32'h84, 1'b0,
             2'b00, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0));
    apply(mk("rab-rel", 1'b1, 2'b00, 64'h0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0,
             2'b00, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0));
    apply(mk("rab-grant2", 1'b1, 2'b01, {32'h0, 32'h5000}, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0,
             2'b01, 1'b0, 32'h0, 2'b00, 1'b0, 1'b0));
    apply(mk("rab-req2", 1'b1, 2'b00, 64'h0, 2'b00, 1'b1, 1'b0, 32'h0, 1'b0,
             2'b00, 1'b1, 32'h5000, 2'b00, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++)
      apply(mk("rab-beat2", 1'b1, 2'b00, 64'h0, 2'b01, 1'b0, 1'b1, 32'h90 + 32'(i), i == 7,
               2'b00, 1'b0, 32'h5000, 2'b01, 1'b1, 1'b0));
    apply(mk("rab-idle", 1'b1, 2'b00, 64'h0, 2'b00, 1'b0, 1'b0, 32'h0, 1'b0,
             2'b00, 1'b0, 32'h5000, 2'b00, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mem_rd_arbiter.md
# mem_rd_arbiter
Two-client arbiter for the single memory read channel shared by the I-cache and D-cache refill paths. Grants one outstanding 8-beat burst read at a time with round-robin fairness, then routes the burst back to the granted client until the `last` beat is handshaken. It sits between the cache miss FSMs (client 0 = I-cache, client 1 = D-cache) and the memory read port.
## Interface
- `BEATS`, 8: data beats per burst; sizes the beat counter, width `$clog2(BEATS)`.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `from_cli_rd_req_valid` in 2: per-client read request valid; bit0 I-cache, bit1 D-cache.
- `from_cli_rd_req_addr` in 64: per-client 32-bit address; [31:0] client0, [63:32] client1; 32-byte aligned.
- `to_cli_rd_req_ready` out 2: per-client request accept, one-hot or zero.
- `to_cli_rd_rsp_valid` out 2: per-client beat valid, one-hot or zero.
- `to_cli_rd_rsp_data` out 32: beat data, broadcast to both clients.
- `to_cli_rd_rsp_last` out 1: last beat; meaningful only with a set `to_cli_rd_rsp_valid` bit.
- `from_cli_rd_rsp_ready` in 2: per-client beat ready.
- `to_mem_rd_req_valid` out 1; `to_mem_rd_req_addr` out 32; `from_mem_rd_req_ready` in 1: memory request channel.
- `from_mem_rd_rsp_valid` in 1; `from_mem_rd_rsp_data` in 32; `from_mem_rd_rsp_last` in 1; `to_mem_rd_rsp_ready` out 1: memory response channel.
- `protocol_err` out 1: sticky; set when a `last`/beat-count mismatch is detected.
## Operation
- FSM is one-hot with three states: IDLE, REQ, RESP. Reset state is IDLE.
- IDLE, at least one client valid: grant one client.
  - Only one valid: that client wins.
  - Both valid: the client not granted last wins. `last_grant` resets to 1, so the I-cache wins the first tie.
  - Grant cycle: `to_cli_rd_req_ready[g]`=1; latch `addr[g]` into `addr_q`, `g` into `grant_q`, update `last_grant`. Next state is REQ.
- REQ: `to_mem_rd_req_valid`=1, `to_mem_rd_req_addr`=`addr_q`, held stable until `from_mem_rd_req_ready`. Then clear the beat counter and go to RESP.
- RESP:
  - `to_cli_rd_rsp_valid[grant_q]` = `from_mem_rd_rsp_valid`. The other bit is 0.
  - Data and `last` pass through combinationally.
  - `to_mem_rd_rsp_ready` = `from_cli_rd_rsp_ready[grant_q]`.
  - Beat handshake (valid && ready): counter increments.
  - Handshake with `last`: go to IDLE.
  - If `last` arrives with counter != BEATS-1, or counter reaches BEATS-1 without `last`, set `protocol_err`. The burst still completes on `last`.
- A client request arriving in REQ or RESP waits. Its ready stays 0 and the arbiter does not latch its address.
- The granted client may deassert its request valid after grant; this has no effect.
- Outside RESP, `to_mem_rd_rsp_ready`=0 and both `to_cli_rd_rsp_valid` bits are 0.
## Timing
- Reset values (asynchronous, immediate on `rst`=0):
  - state IDLE, `grant_q`=0, `last_grant`=1, `addr_q`=0, counter 0, `protocol_err`=0.
  - All `valid` and `ready` outputs 0; `to_mem_rd_req_addr`=0.
- Client request to memory request: 1 cycle (grant cycle, then `to_mem_rd_req_valid` in the next cycle).
- No combinational path from memory request ready to client request ready.
- Response path is combinational in both directions: zero added latency per beat.
- Bubble: 1 cycle in IDLE after each `last` handshake before the next grant. Back-to-back bursts therefore cost 2 cycles of overhead.
- Reset during REQ or RESP aborts the burst. The arbiter drops outstanding memory beats; the memory model is also reset.
- `protocol_err` clears only on reset.
## Structure
- Shared package `mem_arb_pkg`: state encodings `ARB_IDLE`/`ARB_REQ`/`ARB_RESP` (3-bit one-hot), client indices `CLI_IC`=0 and `CLI_DC`=1, default `BEATS`.
- One sub-module: `rr_arb2`, a combinational 2-way round-robin pick from valid bits and `last_grant`. The FSM, counter and routing stay in the top.
## Test plan
- Only the I-cache requests `0x0000_1020`; memory ready after 2 cycles, 8 beats `0x10..0x17` with ready high.
  - I-cache ready in cycle 1; memory valid with addr `0x0000_1020` from cycle 2.
  - I-cache receives 8 beats in order, `last` on `0x17`; D-cache rsp_valid stays 0.
- Both clients request in the same cycle from reset (`0x100`, `0x200`):
  - I-cache granted first, then D-cache after its `last`.
  - Repeat both: the D-cache is not starved; grants alternate.
- D-cache deasserts `rsp_ready` for 3 cycles mid-burst: `to_mem_rd_rsp_ready`=0 for those cycles, no beat lost or duplicated, counter correct.
- I-cache requests during a D-cache RESP: its ready stays 0 until the D-cache `last` handshake plus 1 cycle; then it is granted.
- Memory asserts `last` on beat 5: `protocol_err`=1 next cycle, FSM returns to IDLE, and the next burst proceeds normally.
- `rst` asserted in RESP after 4 beats: all outputs reset asynchronously; after release, a new I-cache request completes normally.
